param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/param_counter.sv | 43 ++++
 tb/tb_param_counter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/param_counter.sv
`default_nettype none
// ============================================================================
// Module      : param_counter
// Description : Free-running counter 0..MAX_COUNT with an asynchronous,
//               active-low reset and a combinational terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module param_counter #(
  parameter  int MAX_COUNT = 255,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  output logic [CW-1:0] count,
  output logic          wrap
);

  localparam logic [CW-1:0] c_max_count = CW'(MAX_COUNT);

  if (MAX_COUNT < 1) begin : g_max_count_check
    $error("param_counter: MAX_COUNT must be at least 1");
  end

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Explicit compare even at power-of-two periods; any out-of-range value
  // falls back to zero on the next edge.
  assign count_d = (count_q >= c_max_count) ? '0 : count_q + CW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = (count_q == c_max_count);

endmodule
`default_nettype wire

// File: tb/tb_param_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_counter
// Description : Randomized self-checking bench for param_counter at
//               MAX_COUNT = 255, 10 and 1 against a cycle-count model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] count_a;
  logic       wrap_a;
  logic [3:0] count_b;
  logic       wrap_b;
  logic [0:0] count_c;
  logic       wrap_c;

  int unsigned n     = 0;  // rising edges seen since the last reset release
  int          total = 0;
  int          bad   = 0;

  param_counter #(.MAX_COUNT(255)) u_dut_a (.clk(clk), .rst(rst), .count(count_a), .wrap(wrap_a));
  param_counter #(.MAX_COUNT(10))  u_dut_b (.clk(clk), .rst(rst), .count(count_b), .wrap(wrap_b));
  param_counter #(.MAX_COUNT(1))   u_dut_c (.clk(clk), .rst(rst), .count(count_c), .wrap(wrap_c));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the count is simply the number of edges since release,
  // reduced modulo the period.
  always @(posedge clk) begin
    if (rst) n = n + 1;
    else     n = 0;
  end

  function automatic logic [31:0] model(input int unsigned max_count);
    return rst ? 32'(n % (max_count + 1)) : 32'd0;
  endfunction

  always @(negedge clk) begin
    check("a_count", 32'(count_a), model(255));
    check("a_wrap",  32'(wrap_a),  32'(model(255) == 255));
    check("b_count", 32'(count_b), model(10));
    check("b_wrap",  32'(wrap_b),  32'(model(10) == 10));
    check("c_count", 32'(count_c), model(1));
    check("c_wrap",  32'(wrap_c),  32'(model(1) == 1));
  end

  // Inputs change only 2 time units after a falling edge, clear of both the
  // model update and the compare.
  task automatic set_rst(input logic v);
    @(negedge clk);
    #2 rst = v;
  endtask

  initial begin
    int run_len;
    int hold_len;

    repeat (3) @(negedge clk);
    #1 check("reset_count_a", 32'(count_a), 32'd0);
    check("reset_wrap_c", 32'(wrap_c), 32'd0);
    #1 rst = 1'b1;

    // 300 observed values: the last one is the 299th edge after release.
    repeat (299) @(posedge clk);
    #1;
    check("pin_a_299", 32'(count_a), 32'd43);
    check("pin_b_299", 32'(count_b), 32'd2);
    check("pin_c_299", 32'(count_c), 32'd1);
    check("pin_wrapc_299", 32'(wrap_c), 32'd1);

    // Asynchronous clear between edges while count_a sits at 137.
    repeat (94) @(posedge clk);
    #1 check("pin_a_137", 32'(count_a), 32'd137);
    set_rst(1'b0);
    #1;
    check("async_clr_a", 32'(count_a), 32'd0);
    check("async_clr_b", 32'(count_b), 32'd0);
    check("async_clr_wrap_c", 32'(wrap_c), 32'd0);
    @(negedge clk);
    set_rst(1'b1);
    @(posedge clk);
    #1 check("first_after_release", 32'(count_a), 32'd1);

    // Reset landing exactly on the terminal count.
    repeat (254) @(posedge clk);
    #1 check("pin_wrap_a_255", 32'(wrap_a), 32'd1);
    check("pin_a_255", 32'(count_a), 32'd255);
    set_rst(1'b0);
    #1;
    check("clr_at_max_count", 32'(count_a), 32'd0);
    check("clr_at_max_wrap", 32'(wrap_a), 32'd0);
    set_rst(1'b1);
    @(posedge clk);
    #1;
    check("restart_after_max", 32'(count_a), 32'd1);
    check("no_wrap_after_max", 32'(wrap_a), 32'd0);

    // Randomized run lengths and reset pulses; the per-cycle compare checks all.
    for (int i = 0; i < 24; i++) begin
      run_len = int'($urandom_range(1, 60));
      repeat (run_len) @(negedge clk);
      if ($urandom_range(0, 2) != 0) begin
        set_rst(1'b0);
        #1 check("rand_async_clr", 32'(count_b), 32'd0);
        hold_len = int'($urandom_range(0, 3));
        repeat (hold_len) @(negedge clk);
        set_rst(1'b1);
      end
    end

    repeat (2) @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
